// File: rtl/softmax_normalize.sv
// Softmax normalization: divides each exp element by the shared sum with one
// bit-serial restoring divider, producing saturated unsigned fixed-point probabilities.
module softmax_normalize #(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] exp_in,
  input  logic [DATA_WIDTH-1:0]            sum_in,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0] prob_out,
  output logic                             busy
);

  localparam int TOT = DATA_WIDTH + FRAC_BITS;
  localparam int CW  = $clog2(TOT);
  localparam int IW  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(TOT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_INPUTS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]                             state;
  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]  exp_r;
  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]  prob_r;
  logic [DATA_WIDTH-1:0]                  sum_r;
  logic [DATA_WIDTH-1:0]                  dvd;
  logic [DATA_WIDTH:0]                    rem;
  logic [TOT-1:0]                         quo;
  logic [IW-1:0]                          idx;
  logic [CW-1:0]                          bit_cnt;

  logic [DATA_WIDTH:0]   rem_sh, rem_nxt, den;
  logic                  ge;
  logic [TOT-1:0]        quo_nxt;
  logic [DATA_WIDTH-1:0] result;
  logic [IW-1:0]         idx_nxt;
  logic                  last_bit;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign prob_out  = prob_r;

  // dvd feeds the dividend MSB first; once the exp bits are shifted out it
  // supplies the FRAC_BITS trailing zeros. sum=0 makes every compare true,
  // so the quotient is all ones and saturates naturally.
  always_comb begin
    den      = {1'b0, sum_r};
    rem_sh   = {rem[DATA_WIDTH-1:0], dvd[DATA_WIDTH-1]};
    ge       = (rem_sh >= den);
    rem_nxt  = ge ? (rem_sh - den) : rem_sh;
    quo_nxt  = {quo[TOT-2:0], ge};
    result   = (|quo_nxt[TOT-1:DATA_WIDTH]) ? '1 : quo_nxt[DATA_WIDTH-1:0];
    idx_nxt  = idx + IW'(1);
    last_bit = (bit_cnt == BIT_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      exp_r   <= '0;
      prob_r  <= '0;
      sum_r   <= '0;
      dvd     <= '0;
      rem     <= '0;
      quo     <= '0;
      idx     <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          exp_r   <= exp_in;
          sum_r   <= sum_in;
          dvd     <= exp_in[DATA_WIDTH-1:0];
          rem     <= '0;
          quo     <= '0;
          idx     <= '0;
          bit_cnt <= '0;
          state   <= DIV;
        end
        DIV: begin
          rem     <= rem_nxt;
          quo     <= quo_nxt;
          dvd     <= {dvd[DATA_WIDTH-2:0], 1'b0};
          bit_cnt <= bit_cnt + CW'(1);
          if (last_bit) begin
            prob_r[idx] <= result;
            rem         <= '0;
            quo         <= '0;
            bit_cnt     <= '0;
            if (idx == IDX_LAST) begin
              state <= DONE;
            end else begin
              idx <= idx_nxt;
              dvd <= exp_r[idx_nxt];
            end
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
